mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/simd_mem_pkg.sv | 6 +
 rtl/burst_addr_gen.sv | 34 +++
 rtl/mem_port_arbiter.sv | 81 ++++++++
 tb/tb_mem_port_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/simd_mem_pkg.sv
// simd_mem_pkg: shared arbiter state encoding, lane type and default starvation threshold
package simd_mem_pkg;
    typedef enum logic {ST_IDLE, ST_HOST} arbState_e;
    typedef logic [7:0] lane_t;
    localparam int DEFAULT_MAX_WAIT = 4;
endpackage

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: latches a burst base/length and walks beat addresses one word per step
module burst_addr_gen #(
    parameter int vecSize = 4,
    parameter int regSize = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [regSize-1:0] baseIn,
    input  logic [3:0]         lenIn,
    output logic [regSize-1:0] addr,
    output logic               last
);
    logic [regSize-1:0] base;
    logic [3:0] len, beat;
    // beat 0 goes out combinationally from the top, so the counter resumes at beat 1
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            base <= '0;
            len  <= '0;
            beat <= '0;
        end else if (load) begin
            base <= baseIn;
            len  <= lenIn;
            beat <= 4'd1;
        end else if (step) begin
            beat <= beat + 4'd1;
        end
    always_comb begin
        addr = base + regSize'(beat) * regSize'(vecSize);
        last = beat == len;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a pipeline and a bursting host with starvation guard
module mem_port_arbiter
    import simd_mem_pkg::*;
#(
    parameter int vecSize  = 4,
    parameter int regSize  = 16,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_req,
    input  logic                 p_we,
    input  logic [regSize-1:0]   p_addr,
    input  logic [vecSize*8-1:0] p_wdata,
    output logic                 p_gnt,
    output logic                 p_stall,
    output logic                 p_rvalid,
    input  logic                 h_req,
    input  logic                 h_we,
    input  logic [regSize-1:0]   h_addr,
    input  logic [3:0]           h_len,
    input  logic [vecSize*8-1:0] h_wdata,
    output logic                 h_gnt,
    output logic                 h_beat,
    output logic                 h_done,
    output logic                 h_busy,
    output logic                 h_rvalid,
    output logic                 mem_we,
    output logic [regSize-1:0]   mem_addr,
    output logic [vecSize*8-1:0] mem_wdata,
    input  logic [vecSize*8-1:0] mem_rdata,
    output logic [vecSize*8-1:0] rdata
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 2);

    arbState_e state, nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic inHost, starve, pWin, hWin, hWeReg, pOwn, hOwn, genLast;
    logic [regSize-1:0] genAddr;

    burst_addr_gen #(.vecSize(vecSize), .regSize(regSize)) addrGen (
        .clk(clk), .rst(rst), .load(hWin), .step(rst && inHost),
        .baseIn(h_addr), .lenIn(h_len), .addr(genAddr), .last(genLast)
    );

    // every output is qualified by rst so nothing reaches memory while reset is held
    always_comb begin
        inHost    = state == ST_HOST;
        starve    = h_req && waitCnt == WAIT_W'(MAX_WAIT);
        pWin      = rst && !inHost && p_req && !starve;
        hWin      = rst && !inHost && !pWin && h_req;
        p_gnt     = pWin;
        p_stall   = rst && p_req && !pWin;
        h_gnt     = hWin;
        h_beat    = hWin || (rst && inHost);
        h_done    = hWin ? h_len == 4'd0 : rst && inHost && genLast;
        h_busy    = rst && inHost;
        mem_we    = pWin ? p_we : hWin ? h_we : h_busy ? hWeReg : 1'b0;
        mem_addr  = pWin ? p_addr : hWin ? h_addr : h_busy ? genAddr : '0;
        mem_wdata = pWin ? p_wdata : h_beat ? h_wdata : '0;
        p_rvalid  = pOwn;
        h_rvalid  = hOwn;
        rdata     = rst ? mem_rdata : '0;
        nextState = (hWin && h_len != 4'd0) ? ST_HOST : (inHost && genLast) ? ST_IDLE : state;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= ST_IDLE;
            waitCnt <= '0;
            hWeReg  <= 1'b0;
            pOwn    <= 1'b0;
            hOwn    <= 1'b0;
        end else begin
            state   <= nextState;
            waitCnt <= hWin ? '0 : (h_req && !inHost && waitCnt != WAIT_W'(MAX_WAIT)) ? waitCnt + WAIT_W'(1) : waitCnt;
            hWeReg  <= hWin ? h_we : hWeReg;
            pOwn    <= pWin && !p_we;
            hOwn    <= h_beat && !mem_we;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for the memory port arbiter
module tb_mem_port_arbiter;
    logic clk = 0, rst;
    logic p_req, p_we, p_gnt, p_stall, p_rvalid;
    logic [15:0] p_addr, h_addr, mem_addr;
    logic [31:0] p_wdata, h_wdata, mem_wdata, mem_rdata, rdata;
    logic h_req, h_we, h_gnt, h_beat, h_done, h_busy, h_rvalid, mem_we;
    logic [3:0] h_len;
    int checkCnt = 0, passCnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_len(h_len), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_beat(h_beat), .h_done(h_done), .h_busy(h_busy), .h_rvalid(h_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rdata(rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0; p_req = 1; p_we = 1; p_addr = 16'h0055; p_wdata = 32'h11223344;
        h_req = 0; h_we = 0; h_addr = 0; h_len = 0; h_wdata = 0; mem_rdata = 32'hAABBCCDD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_p_gnt", p_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_p_stall", p_stall, 0);
        chk("rst_rdata", rdata, 0);

        nextCycle();
        rst = 1; p_addr = 16'h0010; p_wdata = 32'h04030201;
        @(negedge clk);
        chk("p_wr_gnt", p_gnt, 1);
        chk("p_wr_we", mem_we, 1);
        chk("p_wr_addr", mem_addr, 16'h0010);
        chk("p_wr_wdata", mem_wdata, 32'h04030201);
        chk("p_wr_stall", p_stall, 0);

        nextCycle();
        p_we = 0; p_addr = 16'h0020;
        @(negedge clk);
        chk("p_rd_we", mem_we, 0);
        chk("p_rd_addr", mem_addr, 16'h0020);
        nextCycle();
        p_req = 0;
        @(negedge clk);
        chk("p_rvalid", p_rvalid, 1);
        chk("p_rd_h_rvalid", h_rvalid, 0);
        chk("rdata_pass", rdata, 32'hAABBCCDD);
        chk("idle_we", mem_we, 0);
        chk("idle_addr", mem_addr, 0);
        chk("idle_wdata", mem_wdata, 0);

        nextCycle();
        h_req = 1; h_we = 0; h_addr = 16'h0100; h_len = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("h_rd_addr%0d", i), mem_addr, 16'h0100 + 16'(i * 4));
            chk($sformatf("h_rd_gnt%0d", i), h_gnt, i == 0);
            chk($sformatf("h_rd_beat%0d", i), h_beat, 1);
            chk($sformatf("h_rd_done%0d", i), h_done, i == 3);
            chk($sformatf("h_rd_busy%0d", i), h_busy, i != 0);
            chk($sformatf("h_rd_we%0d", i), mem_we, 0);
            if (i > 0) chk($sformatf("h_rvalid%0d", i), h_rvalid, 1);
            nextCycle();
            h_req = 0;
        end
        @(negedge clk);
        chk("h_rvalid_last", h_rvalid, 1);
        chk("h_rd_p_rvalid", p_rvalid, 0);
        chk("h_rd_busy_end", h_busy, 0);

        nextCycle();
        p_req = 1; p_we = 1; p_addr = 16'h0040; h_req = 1; h_we = 1; h_addr = 16'h0200; h_len = 1;
        h_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("starve_p_gnt%0d", i), p_gnt, 1);
            chk($sformatf("starve_h_gnt%0d", i), h_gnt, 0);
            nextCycle();
        end
        @(negedge clk);
        chk("starve_h_gnt", h_gnt, 1);
        chk("starve_p_gnt_off", p_gnt, 0);
        chk("starve_p_stall0", p_stall, 1);
        chk("starve_addr0", mem_addr, 16'h0200);
        nextCycle();
        h_req = 0;
        @(negedge clk);
        chk("starve_addr1", mem_addr, 16'h0204);
        chk("starve_p_stall1", p_stall, 1);
        chk("starve_done", h_done, 1);
        chk("starve_wdata", mem_wdata, 32'hCAFEF00D);
        nextCycle();
        @(negedge clk);
        chk("after_burst_p_gnt", p_gnt, 1);

        nextCycle();
        p_req = 0; h_req = 1; h_addr = 16'hFFFC; h_len = 1;
        @(negedge clk);
        chk("wrap_addr0", mem_addr, 16'hFFFC);
        nextCycle();
        h_req = 0;
        @(negedge clk);
        chk("wrap_addr1", mem_addr, 16'h0000);
        chk("wrap_done", h_done, 1);

        nextCycle();
        h_req = 1; h_addr = 16'h0080; h_len = 0;
        @(negedge clk);
        chk("single_gnt", h_gnt, 1);
        chk("single_beat", h_beat, 1);
        chk("single_done", h_done, 1);
        nextCycle();
        h_req = 0;
        @(negedge clk);
        chk("single_busy", h_busy, 0);

        nextCycle();
        h_req = 1; h_we = 1; h_addr = 16'h0300; h_len = 15; h_wdata = 32'h5A5A5A5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("long_addr%0d", i), mem_addr, 16'h0300 + 16'(i * 4));
            nextCycle();
            h_req = 0;
        end
        @(negedge clk);
        chk("long_we_pre", mem_we, 1);
        rst = 0;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_busy", h_busy, 0);
        chk("midrst_beat", h_beat, 0);
        chk("midrst_addr", mem_addr, 0);
        nextCycle();
        rst = 1;
        @(negedge clk);
        chk("postrst_busy", h_busy, 0);
        chk("postrst_we", mem_we, 0);
        nextCycle();
        h_req = 1; h_addr = 16'h0400; h_len = 1;
        @(negedge clk);
        chk("postrst_gnt", h_gnt, 1);
        chk("postrst_addr0", mem_addr, 16'h0400);
        nextCycle();
        h_req = 0;
        @(negedge clk);
        chk("postrst_addr1", mem_addr, 16'h0404);
        chk("postrst_done", h_done, 1);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
